matmul_ctrl: RTL



---
 rtl/matmul_pkg.sv | 39 +++
 rtl/mm_xbuf.sv | 36 +++
 rtl/matmul_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// Shared types and constants for the matmul_ctrl sequencer: FSM state
// encoding, matrix geometry, lane/word widths and X lane zero-extension.
package matmul_pkg;

  localparam int DATA_W     = 8;                 // input element width
  localparam int COEF_W     = 7;                 // coefficient width
  localparam int ACC_W      = 18;                // accumulator lane width
  localparam int XLANE_W    = DATA_W + 1;        // zero-extended X lane
  localparam int LANES      = 4;
  localparam int K          = 8;                 // MACs per output row
  localparam int ROWS       = 4;                 // output rows per matrix
  localparam int PIPE_DEPTH = 2;                 // issue -> mac_en latency
  localparam int ROW_W      = LANES * DATA_W;    // one X buffer row
  localparam int ROM_W      = 2 * COEF_W;        // two coefficients per word
  localparam int ROM_AW     = 4;
  localparam int XB_AW      = 3;                 // X buffer address width
  localparam int ISSUE_W    = 5;                 // issue index width
  localparam int OUT_AW     = 2;
  localparam int OUT_W      = LANES * ACC_W;

  localparam logic [XB_AW-1:0]   ROW_IDX_LAST = XB_AW'(K - 1);
  localparam logic [ISSUE_W-1:0] ISSUE_LAST   = ISSUE_W'(K * ROWS - 1);
  localparam logic [OUT_AW-1:0]  WR_ROW_LAST  = OUT_AW'(ROWS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMPUTE,
    DRAIN,
    DONE
  } state_t;

  // Pick one element lane (0-based) out of a buffer row and zero-extend it.
  function automatic logic [XLANE_W-1:0] x_lane(input logic [ROW_W-1:0] row,
                                                input int lane);
    return {1'b0, row[lane*DATA_W +: DATA_W]};
  endfunction

endpackage

// File: rtl/mm_xbuf.sv
// X row buffer: 8 x 32-bit register file, one write port used while the
// matrix streams in and one registered read port feeding pipeline stage 1.
module mm_xbuf
  import matmul_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [XB_AW-1:0] wr_addr,
  input  logic [ROW_W-1:0] wr_data,
  input  logic             rd_en,
  input  logic [XB_AW-1:0] rd_addr,
  output logic [ROW_W-1:0] rd_data
);

  logic [ROW_W-1:0] mem [K];

  // Storage write port.
  // NOTE: the array has no reset; its contents are always written before
  // being read, and leaving it out keeps it a plain register file.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port (pipeline stage 1).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/matmul_ctrl.sv
// matmul_ctrl: loads an 8x4 X matrix from a valid/ready stream, walks the
// 32-entry coefficient sequence (16 ROM words), drives the 4-lane MAC
// datapath with ROM latency compensated and writes one result row every
// 8 MACs. Optional status ports (err_start, frame_cnt) are enabled by
// defining MATMUL_CTRL_STATUS_EN.
module matmul_ctrl
  import matmul_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ROW_W-1:0]   in_data,
  output logic               rom_en,
  output logic [ROM_AW-1:0]  rom_addr,
  input  logic [ROM_W-1:0]   rom_data,
  output logic               mac_en,
  output logic               mac_first,
  output logic [COEF_W-1:0]  coef,
  output logic [XLANE_W-1:0] x1,
  output logic [XLANE_W-1:0] x2,
  output logic [XLANE_W-1:0] x3,
  output logic [XLANE_W-1:0] x4,
  input  logic [ACC_W-1:0]   mu1,
  input  logic [ACC_W-1:0]   mu2,
  input  logic [ACC_W-1:0]   mu3,
  input  logic [ACC_W-1:0]   mu4,
  output logic               out_we,
  output logic [OUT_AW-1:0]  out_addr,
  output logic [OUT_W-1:0]   out_data
`ifdef MATMUL_CTRL_STATUS_EN
  ,
  output logic               err_start,
  output logic [7:0]         frame_cnt
`endif
);

  localparam int S2 = PIPE_DEPTH - 1;  // index of the presentation stage

  state_t state, state_nxt;

  logic [ISSUE_W-1:0]    k_cnt;        // issue index 0..31
  logic [XB_AW-1:0]      ld_cnt;       // buffer row being loaded
  logic [OUT_AW-1:0]     wr_row;       // next result row to write
  logic                  issue;
  logic                  load_acc;
  logic [ROW_W-1:0]      xrow_s1;
  logic [PIPE_DEPTH-1:0] vld_pipe;
  logic [PIPE_DEPTH-1:0] odd_pipe;
  logic [PIPE_DEPTH-1:0] first_pipe;
  logic [PIPE_DEPTH-1:0] last_pipe;
  logic                  we_r;

  assign issue    = (state == COMPUTE);
  assign load_acc = (state == LOAD) && in_valid;

  // State register.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and state-derived control outputs.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    in_ready  = 1'b0;
    rom_en    = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (in_valid && ld_cnt == ROW_IDX_LAST) state_nxt = COMPUTE;
      end
      COMPUTE: begin
        busy   = 1'b1;
        rom_en = 1'b1;
        if (k_cnt == ISSUE_LAST) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (we_r && wr_row == WR_ROW_LAST) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Load, issue and write-row counters; all return to 0 by themselves at the
  // end of a matrix and are also cleared when a new matrix is started.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_cnt  <= '0;
      ld_cnt <= '0;
      wr_row <= '0;
    end else begin
      if (state == IDLE && start) begin
        k_cnt  <= '0;
        ld_cnt <= '0;
        wr_row <= '0;
      end
      if (load_acc) ld_cnt <= ld_cnt + 1'b1;
      if (issue)    k_cnt  <= k_cnt + 1'b1;
      if (we_r)     wr_row <= wr_row + 1'b1;
    end
  end

  // Coefficient word holds indices 2a and 2a+1, so the word address is k/2.
  assign rom_addr = k_cnt[ISSUE_W-1:1];

  mm_xbuf u_xbuf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (load_acc),
    .wr_addr (ld_cnt),
    .wr_data (in_data),
    .rd_en   (issue),
    .rd_addr (k_cnt[XB_AW-1:0]),
    .rd_data (xrow_s1)
  );

  // Side-band flags travelling alongside the ROM/buffer read latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe   <= '0;
      odd_pipe   <= '0;
      first_pipe <= '0;
      last_pipe  <= '0;
    end else begin
      vld_pipe   <= {vld_pipe[PIPE_DEPTH-2:0], issue};
      odd_pipe   <= {odd_pipe[PIPE_DEPTH-2:0], k_cnt[0]};
      first_pipe <= {first_pipe[PIPE_DEPTH-2:0], k_cnt[XB_AW-1:0] == '0};
      last_pipe  <= {last_pipe[PIPE_DEPTH-2:0], k_cnt[XB_AW-1:0] == ROW_IDX_LAST};
    end
  end

  // Stage 2: select the coefficient half and register it with the X lanes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      coef <= '0;
      x1   <= '0;
      x2   <= '0;
      x3   <= '0;
      x4   <= '0;
    end else if (vld_pipe[0]) begin
      coef <= odd_pipe[0] ? rom_data[ROM_W-1:COEF_W] : rom_data[COEF_W-1:0];
      x1   <= x_lane(xrow_s1, 0);
      x2   <= x_lane(xrow_s1, 1);
      x3   <= x_lane(xrow_s1, 2);
      x4   <= x_lane(xrow_s1, 3);
    end
  end

  assign mac_en    = vld_pipe[S2];
  assign mac_first = vld_pipe[S2] && first_pipe[S2];

  // Result write fires the cycle after a group's last MAC, once mu holds the
  // finished sum; it overlaps the next group's mac_first harmlessly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_r <= 1'b0;
    end else begin
      we_r <= vld_pipe[S2] && last_pipe[S2];
    end
  end

  assign out_we   = we_r;
  assign out_addr = wr_row;
  assign out_data = we_r ? {mu4, mu3, mu2, mu1} : '0;

`ifdef MATMUL_CTRL_STATUS_EN
  // Sticky start-while-busy flag and completed-matrix counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_start <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (start && state != IDLE) err_start <= 1'b1;
      if (state == DONE)          frame_cnt <= frame_cnt + 1'b1;
    end
  end
`endif

endmodule
